// File: rtl/decode_pkg.sv
// decode_pkg: constants and types shared by the RV32I decode stage and alu.
// Optional feature macro used by the decode files: DECODE_ILLEGAL_TRAP_EN.
package decode_pkg;

   localparam int XLEN = 32;
   localparam int OPW  = 37;

   // One-hot bit positions of the alu opcode vector
   localparam int OP_ADD   = 0;
   localparam int OP_SUB   = 1;
   localparam int OP_XOR   = 2;
   localparam int OP_OR    = 3;
   localparam int OP_AND   = 4;
   localparam int OP_SLL   = 5;
   localparam int OP_SRL   = 6;
   localparam int OP_SRA   = 7;
   localparam int OP_SLT   = 8;
   localparam int OP_SLTU  = 9;
   localparam int OP_ADDI  = 10;
   localparam int OP_XORI  = 11;
   localparam int OP_ORI   = 12;
   localparam int OP_ANDI  = 13;
   localparam int OP_SLLI  = 14;
   localparam int OP_SRLI  = 15;
   localparam int OP_SRAI  = 16;
   localparam int OP_SLTI  = 17;
   localparam int OP_SLTIU = 18;
   localparam int OP_LB    = 19;
   localparam int OP_LH    = 20;
   localparam int OP_LW    = 21;
   localparam int OP_LBU   = 22;
   localparam int OP_LHU   = 23;
   localparam int OP_SB    = 24;
   localparam int OP_SH    = 25;
   localparam int OP_SW    = 26;
   localparam int OP_BEQ   = 27;
   localparam int OP_BNE   = 28;
   localparam int OP_BLT   = 29;
   localparam int OP_BGE   = 30;
   localparam int OP_BLTU  = 31;
   localparam int OP_BGEU  = 32;
   localparam int OP_JAL   = 33;
   localparam int OP_JALR  = 34;
   localparam int OP_LUI   = 35;
   localparam int OP_AUIPC = 36;

   // RV32I major opcodes
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

   // The only two funct7 values that decode
   localparam logic [6:0] F7_BASE = 7'h00;
   localparam logic [6:0] F7_ALT  = 7'h20;

   typedef enum logic [2:0] {
      FMT_I,
      FMT_S,
      FMT_B,
      FMT_U,
      FMT_J,
      FMT_NONE
   } imm_fmt_e;

   typedef struct packed {
      logic [OPW-1:0]  instructions;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic [4:0]      rd;
      logic [XLEN-1:0] imm;
      logic [XLEN-1:0] pc;
      logic            use_imm;
      logic            illegal;
   } dec_bundle_t;

   // Sign-extended immediate for a format; bits [6:0] of the word never
   // contribute, so only [31:7] is passed in.
   function automatic logic [XLEN-1:0] build_imm(input imm_fmt_e fmt, input logic [31:7] w);
      case (fmt)
         FMT_I:   build_imm = {{20{w[31]}}, w[31:20]};
         FMT_S:   build_imm = {{20{w[31]}}, w[31:25], w[11:7]};
         FMT_B:   build_imm = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
         FMT_U:   build_imm = {w[31:12], 12'h000};
         FMT_J:   build_imm = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
         default: build_imm = '0;
      endcase
   endfunction

endpackage

// File: rtl/instr_decode_comb.sv
// instr_decode_comb: purely combinational RV32I word -> decoded bundle.
// With DECODE_ILLEGAL_TRAP_EN defined the bundle flags undecodable words;
// otherwise the illegal flag stays 0 and such words become a zero bundle.
module instr_decode_comb
   import decode_pkg::*;
(
   input  logic [31:0]  instr,
   input  logic [31:0]  pc,
   output dec_bundle_t  bundle
);

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic [6:0] funct7;

   assign opcode = instr[6:0];
   assign funct3 = instr[14:12];
   assign funct7 = instr[31:25];

   logic [OPW-1:0] onehot;
   imm_fmt_e       fmt;
   logic           legal;
   logic           has_rs1;
   logic           has_rs2;
   logic           has_rd;
   logic           imm_sel;

   // Classify the word: one-hot opcode, immediate format and which fields exist
   always_comb begin
      onehot  = '0;
      fmt     = FMT_NONE;
      legal   = 1'b0;
      has_rs1 = 1'b0;
      has_rs2 = 1'b0;
      has_rd  = 1'b0;
      imm_sel = 1'b0;
      case (opcode)
         OPC_OP: begin
            has_rs1 = 1'b1;
            has_rs2 = 1'b1;
            has_rd  = 1'b1;
            if (funct7 == F7_BASE) begin
               legal = 1'b1;
               case (funct3)
                  3'd0:    onehot[OP_ADD]  = 1'b1;
                  3'd1:    onehot[OP_SLL]  = 1'b1;
                  3'd2:    onehot[OP_SLT]  = 1'b1;
                  3'd3:    onehot[OP_SLTU] = 1'b1;
                  3'd4:    onehot[OP_XOR]  = 1'b1;
                  3'd5:    onehot[OP_SRL]  = 1'b1;
                  3'd6:    onehot[OP_OR]   = 1'b1;
                  default: onehot[OP_AND]  = 1'b1;
               endcase
            end else if (funct7 == F7_ALT) begin
               case (funct3)
                  3'd0: begin onehot[OP_SUB] = 1'b1; legal = 1'b1; end
                  3'd5: begin onehot[OP_SRA] = 1'b1; legal = 1'b1; end
                  default: ;
               endcase
            end
         end
         OPC_OPIMM: begin
            fmt     = FMT_I;
            has_rs1 = 1'b1;
            has_rd  = 1'b1;
            imm_sel = 1'b1;
            case (funct3)
               3'd0: begin onehot[OP_ADDI]  = 1'b1; legal = 1'b1; end
               3'd2: begin onehot[OP_SLTI]  = 1'b1; legal = 1'b1; end
               3'd3: begin onehot[OP_SLTIU] = 1'b1; legal = 1'b1; end
               3'd4: begin onehot[OP_XORI]  = 1'b1; legal = 1'b1; end
               3'd6: begin onehot[OP_ORI]   = 1'b1; legal = 1'b1; end
               3'd7: begin onehot[OP_ANDI]  = 1'b1; legal = 1'b1; end
               3'd1: begin
                  if (funct7 == F7_BASE) begin onehot[OP_SLLI] = 1'b1; legal = 1'b1; end
               end
               default: begin
                  if (funct7 == F7_BASE) begin
                     onehot[OP_SRLI] = 1'b1;
                     legal = 1'b1;
                  end else if (funct7 == F7_ALT) begin
                     onehot[OP_SRAI] = 1'b1;
                     legal = 1'b1;
                  end
               end
            endcase
         end
         OPC_LOAD: begin
            fmt     = FMT_I;
            has_rs1 = 1'b1;
            has_rd  = 1'b1;
            imm_sel = 1'b1;
            case (funct3)
               3'd0: begin onehot[OP_LB]  = 1'b1; legal = 1'b1; end
               3'd1: begin onehot[OP_LH]  = 1'b1; legal = 1'b1; end
               3'd2: begin onehot[OP_LW]  = 1'b1; legal = 1'b1; end
               3'd4: begin onehot[OP_LBU] = 1'b1; legal = 1'b1; end
               3'd5: begin onehot[OP_LHU] = 1'b1; legal = 1'b1; end
               default: ;
            endcase
         end
         OPC_STORE: begin
            fmt     = FMT_S;
            has_rs1 = 1'b1;
            has_rs2 = 1'b1;
            imm_sel = 1'b1;
            case (funct3)
               3'd0: begin onehot[OP_SB] = 1'b1; legal = 1'b1; end
               3'd1: begin onehot[OP_SH] = 1'b1; legal = 1'b1; end
               3'd2: begin onehot[OP_SW] = 1'b1; legal = 1'b1; end
               default: ;
            endcase
         end
         OPC_BRANCH: begin
            fmt     = FMT_B;
            has_rs1 = 1'b1;
            has_rs2 = 1'b1;
            case (funct3)
               3'd0: begin onehot[OP_BEQ]  = 1'b1; legal = 1'b1; end
               3'd1: begin onehot[OP_BNE]  = 1'b1; legal = 1'b1; end
               3'd4: begin onehot[OP_BLT]  = 1'b1; legal = 1'b1; end
               3'd5: begin onehot[OP_BGE]  = 1'b1; legal = 1'b1; end
               3'd6: begin onehot[OP_BLTU] = 1'b1; legal = 1'b1; end
               3'd7: begin onehot[OP_BGEU] = 1'b1; legal = 1'b1; end
               default: ;
            endcase
         end
         OPC_JAL: begin
            fmt    = FMT_J;
            has_rd = 1'b1;
            onehot[OP_JAL] = 1'b1;
            legal  = 1'b1;
         end
         OPC_JALR: begin
            fmt     = FMT_I;
            has_rs1 = 1'b1;
            has_rd  = 1'b1;
            imm_sel = 1'b1;
            if (funct3 == 3'd0) begin onehot[OP_JALR] = 1'b1; legal = 1'b1; end
         end
         OPC_LUI: begin
            fmt     = FMT_U;
            has_rd  = 1'b1;
            imm_sel = 1'b1;
            onehot[OP_LUI] = 1'b1;
            legal   = 1'b1;
         end
         OPC_AUIPC: begin
            fmt     = FMT_U;
            has_rd  = 1'b1;
            imm_sel = 1'b1;
            onehot[OP_AUIPC] = 1'b1;
            legal   = 1'b1;
         end
         default: ;
      endcase
   end

   // Assemble the bundle; an undecodable word collapses to all-zero fields
   always_comb begin
      bundle    = '0;
      bundle.pc = pc;
      if (legal) begin
         bundle.instructions = onehot;
         bundle.rs1          = has_rs1 ? instr[19:15] : 5'd0;
         bundle.rs2          = has_rs2 ? instr[24:20] : 5'd0;
         bundle.rd           = has_rd  ? instr[11:7]  : 5'd0;
         bundle.imm          = build_imm(fmt, instr[31:7]);
         bundle.use_imm      = imm_sel;
      end
`ifdef DECODE_ILLEGAL_TRAP_EN
      bundle.illegal = ~legal;
`else
      bundle.illegal = 1'b0;
`endif
   end

endmodule

// File: rtl/instr_decoder.sv
// instr_decoder: registered RV32I decode stage with a one-entry skid buffer.
// Handshake: a transfer happens on a rising edge where valid && ready; once
// out_valid rises the bundle holds until out_ready takes it, and in_ready
// is a flop ("skid empty") so upstream never sees out_ready combinationally.
// Optional feature macro: DECODE_ILLEGAL_TRAP_EN (flag illegal words and
// stop accepting input after one has been taken downstream, until rst).
module instr_decoder #(
   parameter int XLEN = 32,
   parameter int OPW  = 37
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [XLEN-1:0] in_instr,
   input  logic [XLEN-1:0] in_pc,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [OPW-1:0]  instructions,
   output logic [4:0]      rs1,
   output logic [4:0]      rs2,
   output logic [4:0]      rd,
   output logic [XLEN-1:0] imm,
   output logic [XLEN-1:0] pc_out,
   output logic            use_imm,
   output logic            illegal
);

   decode_pkg::dec_bundle_t dec_b;
   decode_pkg::dec_bundle_t out_q;
   decode_pkg::dec_bundle_t out_d;
   decode_pkg::dec_bundle_t skid_q;
   decode_pkg::dec_bundle_t skid_d;
   logic out_valid_q, out_valid_d;
   logic skid_valid_q, skid_valid_d;
   logic ready_q, ready_d;
   logic accept;
   logic trap_d;

   instr_decode_comb u_decode (
      .instr  (in_instr),
      .pc     (in_pc),
      .bundle (dec_b)
   );

   assign accept = in_valid && ready_q;

`ifdef DECODE_ILLEGAL_TRAP_EN
   logic trap_q;
   assign trap_d = trap_q || (out_valid_q && out_ready && out_q.illegal);

   // Trap-hold latch: set once an illegal bundle leaves, cleared only by rst
   always_ff @(posedge clk or posedge rst) begin
      if (rst) trap_q <= 1'b0;
      else     trap_q <= trap_d;
   end
`else
   assign trap_d = 1'b0;
`endif

   // Next state of the output and skid registers
   always_comb begin
      out_d        = out_q;
      skid_d       = skid_q;
      out_valid_d  = out_valid_q;
      skid_valid_d = skid_valid_q;
      if (!out_valid_q || out_ready) begin
         // Output slot is free this edge: skid has priority over new input
         if (skid_valid_q) begin
            out_d        = skid_q;
            out_valid_d  = 1'b1;
            skid_valid_d = 1'b0;
         end else if (accept) begin
            out_d       = dec_b;
            out_valid_d = 1'b1;
         end else begin
            out_valid_d = 1'b0;
         end
      end else if (accept) begin
         // Output stalled: park the new word in the skid
         skid_d       = dec_b;
         skid_valid_d = 1'b1;
      end
      ready_d = !skid_valid_d && !trap_d;
   end

   // Pipeline registers; reset discards both entries
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_q        <= '0;
         skid_q       <= '0;
         out_valid_q  <= 1'b0;
         skid_valid_q <= 1'b0;
         ready_q      <= 1'b1;
      end else begin
         out_q        <= out_d;
         skid_q       <= skid_d;
         out_valid_q  <= out_valid_d;
         skid_valid_q <= skid_valid_d;
         ready_q      <= ready_d;
      end
   end

   assign in_ready     = ready_q;
   assign out_valid    = out_valid_q;
   assign instructions = out_q.instructions;
   assign rs1          = out_q.rs1;
   assign rs2          = out_q.rs2;
   assign rd           = out_q.rd;
   assign imm          = out_q.imm;
   assign pc_out       = out_q.pc;
   assign use_imm      = out_q.use_imm;
   assign illegal      = out_q.illegal;

endmodule

// File: tb/tb_instr_decoder.sv
// tb_instr_decoder: randomized and directed stimulus for instr_decoder,
// checked every cycle against a table-driven decode model and an in-order
// expected queue. Honours DECODE_ILLEGAL_TRAP_EN like the design.
module tb_instr_decoder;

   typedef struct packed {
      logic [36:0] instructions;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [31:0] imm;
      logic [31:0] pc;
      logic        use_imm;
      logic        illegal;
   } exp_t;
   localparam int BW = $bits(exp_t);

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_instr;
   logic [31:0] in_pc;
   logic        out_valid;
   logic        out_ready;
   logic [36:0] instructions;
   logic [4:0]  rs1, rs2, rd;
   logic [31:0] imm;
   logic [31:0] pc_out;
   logic        use_imm;
   logic        illegal;

   instr_decoder dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_instr     (in_instr),
      .in_pc        (in_pc),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .instructions (instructions),
      .rs1          (rs1),
      .rs2          (rs2),
      .rd           (rd),
      .imm          (imm),
      .pc_out       (pc_out),
      .use_imm      (use_imm),
      .illegal      (illegal)
   );

   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // Row index is the one-hot bit; -1 means "field not checked".
   int tbl_opc[37] = '{'h33,'h33,'h33,'h33,'h33,'h33,'h33,'h33,'h33,'h33,
                       'h13,'h13,'h13,'h13,'h13,'h13,'h13,'h13,'h13,
                       'h03,'h03,'h03,'h03,'h03,
                       'h23,'h23,'h23,
                       'h63,'h63,'h63,'h63,'h63,'h63,
                       'h6F,'h67,'h37,'h17};
   int tbl_f3[37]  = '{0,0,4,6,7,1,5,5,2,3,
                       0,4,6,7,1,5,5,2,3,
                       0,1,2,4,5,
                       0,1,2,
                       0,1,4,5,6,7,
                       -1,0,-1,-1};
   int tbl_f7[37]  = '{0,32,0,0,0,0,0,32,0,0,
                       -1,-1,-1,-1,0,0,32,-1,-1,
                       -1,-1,-1,-1,-1,
                       -1,-1,-1,
                       -1,-1,-1,-1,-1,-1,
                       -1,-1,-1,-1};

   // 0=R 1=I 2=S 3=B 4=U 5=J
   function automatic int fmt_of(input int b);
      if (b <= 9) return 0;
      if (b <= 23 || b == 34) return 1;
      if (b <= 26) return 2;
      if (b <= 32) return 3;
      if (b == 33) return 5;
      return 4;
   endfunction

   function automatic logic [BW-1:0] model(input logic [31:0] w, input logic [31:0] pc);
      exp_t e;
      int   hit;
      int   f;
      int   v;
      e     = '0;
      e.pc  = pc;
      hit   = -1;
      for (int i = 0; i < 37; i++) begin
         if (int'(w[6:0]) == tbl_opc[i] &&
             (tbl_f3[i] < 0 || int'(w[14:12]) == tbl_f3[i]) &&
             (tbl_f7[i] < 0 || int'(w[31:25]) == tbl_f7[i]))
            hit = i;
      end
      if (hit < 0) begin
`ifdef DECODE_ILLEGAL_TRAP_EN
         e.illegal = 1'b1;
`endif
         return e;
      end
      e.instructions = 37'd1 << hit;
      f = fmt_of(hit);
      e.rs1     = (f <= 3) ? w[19:15] : 5'd0;
      e.rs2     = (f == 0 || f == 2 || f == 3) ? w[24:20] : 5'd0;
      e.rd      = (f == 0 || f == 1 || f == 4 || f == 5) ? w[11:7] : 5'd0;
      e.use_imm = (f == 1 || f == 2 || f == 4);
      case (f)
         1:       v = int'(w[30:20]) - (w[31] ? 2048 : 0);
         2:       v = int'(w[30:25]) * 32 + int'(w[11:7]) - (w[31] ? 2048 : 0);
         3:       v = int'(w[7]) * 2048 + int'(w[30:25]) * 32 + int'(w[11:8]) * 2 - (w[31] ? 4096 : 0);
         5:       v = int'(w[19:12]) * 4096 + int'(w[20]) * 2048 + int'(w[30:21]) * 2 - (w[31] ? 1048576 : 0);
         default: v = 0;
      endcase
      if (f == 4) e.imm = w[31:12] * 32'd4096;
      else        e.imm = v;
      return e;
   endfunction

   // ---------------- scoreboard ----------------
   logic [BW-1:0] exp_q[$];
   logic          trap_m = 1'b0;

   // Outputs are sampled on the falling edge; the handshakes seen here are
   // exactly what the next rising edge will act on.
   always @(negedge clk) begin : compare
      logic [BW-1:0] act;
      logic [BW-1:0] popped;
      act = {instructions, rs1, rs2, rd, imm, pc_out, use_imm, illegal};
      if (rst) begin
         exp_q.delete();
         trap_m = 1'b0;
         check("rst_out_valid", out_valid, 1'b0);
         check("rst_in_ready", in_ready, 1'b1);
         check("rst_bundle", act, '0);
      end else begin
         check("out_valid", out_valid, exp_q.size() > 0);
         check("in_ready", in_ready, (exp_q.size() < 2) && !trap_m);
         if (out_valid && exp_q.size() > 0) check("bundle", act, exp_q[0]);
         if (out_valid && out_ready && exp_q.size() > 0) begin
            popped = exp_q.pop_front();
`ifdef DECODE_ILLEGAL_TRAP_EN
            if (popped[0]) trap_m = 1'b1;
`endif
         end
         if (in_valid && in_ready) exp_q.push_back(model(in_instr, in_pc));
      end
   end

   // ---------------- driver tasks ----------------
   // Present a word and hold it until taken; called just after a rising edge.
   task automatic send(input logic [31:0] w, input logic [31:0] pc);
      int n;
      in_valid = 1'b1;
      in_instr = w;
      in_pc    = pc;
      n = 0;
      forever begin
         @(negedge clk);
         if (in_ready) break;
         n++;
         if (n > 200) begin
            check("send_timeout", 1'b1, 1'b0);
            break;
         end
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic pulse_reset();
      rst      = 1'b1;
      in_valid = 1'b0;
      @(negedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while ((exp_q.size() != 0 || out_valid) && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("drain_timeout", n < 100, 1'b1);
      @(posedge clk);
      #1;
   endtask

   logic [6:0] opcs[9] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17};

   function automatic logic [31:0] gen_word();
      logic [31:0] w;
      int          k;
      w = $urandom();
      k = $urandom_range(0, 39);
      if (k == 0) return 32'h0000_0000;
      if (k == 1) return 32'hFFFF_FFFF;
      if (k == 2) return w;
      w[6:0] = opcs[$urandom_range(0, 8)];
      case ($urandom_range(0, 3))
         0, 1:    w[31:25] = 7'h00;
         2:       w[31:25] = 7'h20;
         default: ;
      endcase
      return w;
   endfunction

   // ---------------- main sequence ----------------
   initial begin : main
      exp_t        e;
      logic [31:0] bp_w[4];
      logic [31:0] pc_ctr;
      logic        took;

      rst       = 1'b0;
      in_valid  = 1'b0;
      in_instr  = '0;
      in_pc     = '0;
      out_ready = 1'b1;
      #1 rst = 1'b1;
      repeat (2) @(negedge clk);
      @(posedge clk);
      #1 rst = 1'b0;

      // Pin the model with hand-decoded words
      e = model(32'h002081B3, 32'h0);
      check("model_add", {e.instructions, e.rs1, e.rs2, e.rd, e.use_imm, e.imm},
            {37'h1, 5'd1, 5'd2, 5'd3, 1'b0, 32'h0});
      e = model(32'hFFF00093, 32'h0);
      check("model_addi", {e.instructions, e.rd, e.use_imm, e.imm},
            {37'h400, 5'd1, 1'b1, 32'hFFFFFFFF});
      e = model(32'h123452B7, 32'h0);
      check("model_lui", {e.instructions, e.rd, e.rs1, e.imm},
            {37'h800000000, 5'd5, 5'd0, 32'h12345000});
      e = model(32'h4030D093, 32'h0);
      check("model_srai", {e.instructions, e.imm}, {37'h10000, 32'h403});
      e = model(32'h0030D093, 32'h0);
      check("model_srli", e.instructions, 37'h8000);
      e = model(32'h6030D093, 32'h0);
      check("model_bad_f7", e.instructions, 37'h0);
      e = model(32'hFE000EE3, 32'h0);   // beq x0,x0,-4
      check("model_beq_imm", {e.instructions, e.imm}, {37'h8000000, 32'hFFFFFFFC});

      // Directed decode with out_ready held high
      send(32'h002081B3, 32'h100);
      @(negedge clk);
      check("add_valid", out_valid, 1'b1);
      check("add_fields", {instructions, rs1, rs2, rd, use_imm, imm, pc_out},
            {37'h1, 5'd1, 5'd2, 5'd3, 1'b0, 32'h0, 32'h100});
      @(posedge clk); #1;
      send(32'hFFF00093, 32'h104);
      @(negedge clk);
      check("addi_fields", {instructions, rd, use_imm, imm}, {37'h400, 5'd1, 1'b1, 32'hFFFFFFFF});
      @(posedge clk); #1;
      send(32'h123452B7, 32'h108);
      @(negedge clk);
      check("lui_fields", {instructions, rd, rs1, imm}, {37'h800000000, 5'd5, 5'd0, 32'h12345000});
      @(posedge clk); #1;
      send(32'h4030D093, 32'h10C);
      @(negedge clk);
      check("srai_fields", {instructions, imm[4:0]}, {37'h10000, 5'd3});
      @(posedge clk); #1;
      send(32'h0030D093, 32'h110);
      @(negedge clk);
      check("srli_fields", instructions, 37'h8000);
      @(posedge clk); #1;
      wait_drain();

      // Backpressure: four words with out_ready low for three cycles
      bp_w[0] = 32'h002081B3;
      bp_w[1] = 32'hFFF00093;
      bp_w[2] = 32'h123452B7;
      bp_w[3] = 32'h0030D093;
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_instr  = bp_w[0];
      in_pc     = 32'h200;
      @(posedge clk); #1;
      in_instr = bp_w[1];
      in_pc    = 32'h204;
      @(posedge clk); #1;
      in_instr = bp_w[2];
      in_pc    = 32'h208;
      @(negedge clk);
      check("bp_in_ready_low", in_ready, 1'b0);
      check("bp_hold_w1", {instructions, pc_out}, {37'h1, 32'h200});
      @(posedge clk); #1;
      @(negedge clk);
      check("bp_still_w1", {out_valid, instructions, pc_out}, {1'b1, 37'h1, 32'h200});
      @(posedge clk); #1;
      out_ready = 1'b1;
      send(bp_w[2], 32'h208);
      send(bp_w[3], 32'h20C);
      wait_drain();

      // Reset in mid-stall: both held entries vanish
      out_ready = 1'b0;
      send(32'h00C58533, 32'h300);
      send(32'h40C58533, 32'h304);
      pulse_reset();
      out_ready = 1'b1;
      repeat (4) begin
         @(negedge clk);
         check("after_reset_empty", out_valid, 1'b0);
      end
      @(posedge clk); #1;

      // Randomized traffic
      pc_ctr = 32'h1000;
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         took = in_valid && in_ready;
         @(posedge clk); #1;
         if (trap_m) begin
            pulse_reset();
         end else if (!in_valid || took) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_instr = gen_word();
            in_pc    = pc_ctr;
            pc_ctr   = pc_ctr + 32'd4;
         end
         out_ready = ($urandom_range(0, 2) != 0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      wait_drain();

      // All-zero word: trap-hold or flow-through depending on build
      pulse_reset();
      send(32'h0000_0000, 32'h400);
      @(negedge clk);
      check("zero_word_valid", out_valid, 1'b1);
      check("zero_word_instr", instructions, 37'h0);
`ifdef DECODE_ILLEGAL_TRAP_EN
      check("zero_word_illegal", illegal, 1'b1);
      repeat (5) begin
         @(negedge clk);
         check("trap_hold", in_ready, 1'b0);
      end
      @(posedge clk); #1;
      pulse_reset();
      @(negedge clk);
      check("trap_released", in_ready, 1'b1);
      @(posedge clk); #1;
`else
      check("zero_word_illegal", illegal, 1'b0);
      @(posedge clk); #1;
      send(32'h002081B3, 32'h404);
      @(negedge clk);
      check("after_zero_add", {out_valid, instructions, pc_out}, {1'b1, 37'h1, 32'h404});
      @(posedge clk); #1;
`endif
      wait_drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/instr_decoder.md
# instr_decoder

Decode stage that turns a fetched 32-bit RV32I instruction word into the 37-bit one-hot `instructions` vector consumed by `alu`, plus register indices and a sign-extended immediate. It sits between fetch and register read/execute. It is a one-cycle registered stage with valid/ready handshakes on both sides and a one-entry skid buffer, so upstream never sees combinational backpressure from downstream.

## Interface
Parameters:
- `XLEN`, 32: instruction, PC and immediate width.
- `OPW`, 37: one-hot opcode vector width. Fixed by the `alu` encoding.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `in_valid`, in, 1: fetch word is valid.
- `in_ready`, out, 1: stage can accept a word.
- `in_instr`, in, 32: raw instruction word.
- `in_pc`, in, 32: PC of `in_instr`.
- `out_valid`, out, 1: decoded bundle is valid.
- `out_ready`, in, 1: downstream accepts the bundle.
- `instructions`, out, 37: one-hot opcode, or zero when illegal.
- `rs1`, `rs2`, `rd`, out, 5 each: register indices (see Operation).
- `imm`, out, 32: sign-extended immediate for the format.
- `pc_out`, out, 32: PC passed through.
- `use_imm`, out, 1: operand 2 is `imm`, not `rs2` data.
- `illegal`, out, 1: word did not decode.

## Operation
- One-hot bit map:
  - Register ops: 0 add, 1 sub, 2 xor, 3 or, 4 and, 5 sll, 6 srl, 7 sra, 8 slt, 9 sltu.
  - Immediate ops: 10 addi, 11 xori, 12 ori, 13 andi, 14 slli, 15 srli, 16 srai, 17 slti, 18 sltiu.
  - Loads: 19 lb, 20 lh, 21 lw, 22 lbu, 23 lhu.
  - Stores: 24 sb, 25 sh, 26 sw.
  - Branches: 27 beq, 28 bne, 29 blt, 30 bge, 31 bltu, 32 bgeu.
  - Jumps and upper-immediate: 33 jal, 34 jalr, 35 lui, 36 auipc.
- At most one bit is set in any accepted bundle.
- Decode keys on opcode[6:0], funct3 and funct7.
  - funct7 must be 0x00, or 0x20 for sub, sra and srai. Any other value is illegal.
  - slli, srli and srai require instr[31:25] to be legal per the above. The shift amount is imm[4:0].
- Immediate formats, all sign-extended from instr[31]:
  - I: loads, OP-IMM, jalr.
  - S: stores.
  - B: branches, bit 0 = 0.
  - U: lui, auipc; value is instr[31:12]<<12.
  - J: jal, bit 0 = 0.
  - R-type: `imm` = 0.
- Register index fields:
  - `rs1` = instr[19:15], `rs2` = instr[24:20], `rd` = instr[11:7] when the format has them. Otherwise 0.
  - Stores and branches: `rd` = 0.
  - lui, auipc, jal: `rs1` = 0.
- `use_imm` = 1 for OP-IMM, loads, stores, jalr, lui, auipc. Otherwise 0.
- Illegal word: any unlisted opcode/funct combination, including 0x00000000 and 0xFFFFFFFF. Forces `instructions` = 0, `imm` = 0 and all indices = 0.

## Timing
- Latency: a word accepted on edge N (`in_valid`&&`in_ready`) has its bundle valid after edge N.
- Output register:
  - Loads when empty, or when `out_ready` is high in the same cycle.
  - Otherwise the accepted word goes to the skid register.
- `in_ready` is registered, equal to "skid empty". It does not depend combinationally on `out_ready`.
- Skid handling:
  - When the output drains (`out_ready` high) and the skid is full, the skid moves to the output on that edge and the skid empties.
  - A new input cannot be taken in that same cycle, because `in_ready` = 0.
- Output stability: while `out_valid` && !`out_ready`, all output fields hold stable.
- Back-to-back: with `out_ready` held high, throughput is 1 word per cycle with no bubbles.
- Reset: asynchronous, takes effect immediately. Reset values:
  - `out_valid` = 0, `in_ready` = 1, `illegal` = 0.
  - All data outputs = 0, skid cleared.
  - Reset in mid-stall discards both entries. Nothing is replayed.

## Configuration
- `DECODE_ILLEGAL_TRAP_EN` defined:
  - An illegal word sets `illegal` = 1 for its bundle.
  - After that bundle is accepted downstream, `in_ready` stays 0 (trap-hold) until `rst`.
- Not defined:
  - `illegal` is tied 0.
  - Illegal words flow as a bundle with all-zero `instructions`, so `alu` produces 0 via its default, and the pipeline keeps running.

## Structure
- Package `decode_pkg` holds:
  - `OPW` and the 37 `OP_*` bit-index constants shared with `alu`.
  - RV32I opcode constants (`OPC_OP`, `OPC_OPIMM`, `OPC_LOAD`, `OPC_STORE`, `OPC_BRANCH`, `OPC_JAL`, `OPC_JALR`, `OPC_LUI`, `OPC_AUIPC`).
  - An `imm_fmt_e` enum (I, S, B, U, J, NONE).
  - A `dec_bundle_t` struct for the output fields.
- Sub-module `instr_decode_comb`: purely combinational word-to-bundle decode. The top level instantiates it once and holds the output and skid registers plus handshake logic.

## Test plan
- 0x002081B3 (add x3,x1,x2), `out_ready`=1 -> next cycle `instructions`=37'h1, rs1=1, rs2=2, rd=3, use_imm=0, imm=0.
- 0xFFF00093 (addi x1,x0,-1) -> `instructions`=37'h400, imm=0xFFFFFFFF, use_imm=1, rd=1.
- 0x123452B7 (lui x5,0x12345) -> `instructions`=37'h800000000, imm=0x12345000, rd=5, rs1=0.
- 0x4030D093 (srai x1,x1,3) -> `instructions`=37'h10000, imm[4:0]=3.
  - 0x0030D093 (srli) -> 37'h8000.
  - 0x6030D093 -> illegal, `instructions`=0.
- Backpressure: stream 4 words with `out_ready`=0 for 3 cycles.
  - `in_ready` drops after the second word is accepted.
  - Output holds word 1. Release -> words 1 to 4 delivered in order, none lost or duplicated.
- 0x00000000 with `DECODE_ILLEGAL_TRAP_EN` -> `illegal`=1, `instructions`=0, then `in_ready` stays 0 until `rst` pulses. Without the macro -> zero bundle and the next word is accepted normally.
